ece453_seg7_display: RTL and testbench

- Downstream consumer of the ECE453 register/FSM block. It takes a 16-bit value (FSM state, a counter or a software value routed from the GPIO outputs) and displays it on a 4-digit common-anode multiplexed 7-segment display.
- Conversion to digits is sequential: shift-add-3 binary-to-BCD in decimal mode, or nibble split in hex mode.
- A free-running refresh counter scans the four digits.

---
 rtl/ece453_seg7_display.sv | 253 +++++++++++++++++++++++++
 tb/tb_ece453_seg7_display.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ece453_seg7_display.sv
// ece453_seg7_display
// Takes a 16-bit value from the ECE453 register/FSM block and shows it on a
// 4-digit, common-anode, multiplexed 7-segment display.
// A load starts a fixed 17-cycle conversion. Decimal mode uses the
// shift-add-3 method. Hex mode splits the value into nibbles. The result is
// then committed to a display register, which a free-running scanner shows
// one digit at a time.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high
//   value_in     value to display, sampled on an accepted load
//   load         single-cycle conversion request
//   mode_dec     1 = decimal (BCD), 0 = hex; sampled with value_in
//   blank_lz     1 = blank leading zeros (decimal only); sampled with value_in
//   enable       0 = display dark and scan halted
//   seg_n        segments {g,f,e,d,c,b,a}, active-low
//   digit_sel_n  digit anodes, active-low one-hot, bit0 = least significant
//   busy         conversion in progress
//   overflow     last committed decimal value was > 9999
module ece453_seg7_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        mode_dec,
  input  logic        blank_lz,
  input  logic        enable,
  output logic [6:0]  seg_n,
  output logic [3:0]  digit_sel_n,
  output logic        busy,
  output logic        overflow
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] val_reg, val_next;
  logic [15:0] bin_reg, bin_next;
  logic [15:0] bcd_reg, bcd_next;
  logic        dec_reg, dec_next;
  logic        blank_reg, blank_next;

  logic        pend_reg, pend_next;
  logic [15:0] pend_val_reg, pend_val_next;
  logic        pend_dec_reg, pend_dec_next;
  logic        pend_blank_reg, pend_blank_next;

  logic [15:0] disp_reg, disp_next;
  logic        disp_dec_reg, disp_dec_next;
  logic        disp_blank_reg, disp_blank_next;
  logic        overflow_reg, overflow_next;

  logic [CW-1:0] refresh_cnt_reg;
  logic [1:0]    idx_reg;
  logic [6:0]    seg_n_reg;
  logic [3:0]    digit_sel_n_reg;

  // Add 3 to every BCD nibble that is >= 5 before each shift.
  logic [15:0] bcd_adj;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_add3
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  // lz_zero[i]: digit i and every digit above it are zero. Digit0 is never blanked.
  logic [3:0] lz_zero;
  assign lz_zero[0] = 1'b0;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_lz
      assign lz_zero[gi] = (disp_reg[15:4*gi] == '0);
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    val_next        = val_reg;
    bin_next        = bin_reg;
    bcd_next        = bcd_reg;
    dec_next        = dec_reg;
    blank_next      = blank_reg;
    pend_next       = pend_reg;
    pend_val_next   = pend_val_reg;
    pend_dec_next   = pend_dec_reg;
    pend_blank_next = pend_blank_reg;
    disp_next       = disp_reg;
    disp_dec_next   = disp_dec_reg;
    disp_blank_next = disp_blank_reg;
    overflow_next   = overflow_reg;

    case (state_reg)
      IDLE: begin
        // A fresh load takes priority over an older pending request.
        if (load) begin
          val_next   = value_in;
          bin_next   = value_in;
          bcd_next   = '0;
          dec_next   = mode_dec;
          blank_next = blank_lz;
          pend_next  = 1'b0;
          cnt_next   = '0;
          state_next = CONV;
        end else if (pend_reg) begin
          val_next   = pend_val_reg;
          bin_next   = pend_val_reg;
          bcd_next   = '0;
          dec_next   = pend_dec_reg;
          blank_next = pend_blank_reg;
          pend_next  = 1'b0;
          cnt_next   = '0;
          state_next = CONV;
        end
      end
      CONV: begin
        // In hex mode the work register is held, so both modes take the same time.
        if (dec_reg) begin
          bcd_next = {bcd_adj[14:0], bin_reg[15]};
          bin_next = {bin_reg[14:0], 1'b0};
        end
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd15) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        disp_next       = dec_reg ? bcd_reg : val_reg;
        disp_dec_next   = dec_reg;
        disp_blank_next = blank_reg;
        overflow_next   = dec_reg && (val_reg > 16'd9999);
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A load that arrives while busy is buffered. Only the last one is kept.
    if (load && (state_reg != IDLE)) begin
      pend_next       = 1'b1;
      pend_val_next   = value_in;
      pend_dec_next   = mode_dec;
      pend_blank_next = blank_lz;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      val_reg        <= '0;
      bin_reg        <= '0;
      bcd_reg        <= '0;
      dec_reg        <= 1'b0;
      blank_reg      <= 1'b0;
      pend_reg       <= 1'b0;
      pend_val_reg   <= '0;
      pend_dec_reg   <= 1'b0;
      pend_blank_reg <= 1'b0;
      disp_reg       <= '0;
      disp_dec_reg   <= 1'b0;
      disp_blank_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      val_reg        <= val_next;
      bin_reg        <= bin_next;
      bcd_reg        <= bcd_next;
      dec_reg        <= dec_next;
      blank_reg      <= blank_next;
      pend_reg       <= pend_next;
      pend_val_reg   <= pend_val_next;
      pend_dec_reg   <= pend_dec_next;
      pend_blank_reg <= pend_blank_next;
      disp_reg       <= disp_next;
      disp_dec_reg   <= disp_dec_next;
      disp_blank_reg <= disp_blank_next;
      overflow_reg   <= overflow_next;
    end
  end

  function automatic logic [6:0] seg_hex(input logic [3:0] d);
    case (d)
      4'h0: seg_hex = 7'h40;
      4'h1: seg_hex = 7'h79;
      4'h2: seg_hex = 7'h24;
      4'h3: seg_hex = 7'h30;
      4'h4: seg_hex = 7'h19;
      4'h5: seg_hex = 7'h12;
      4'h6: seg_hex = 7'h02;
      4'h7: seg_hex = 7'h78;
      4'h8: seg_hex = 7'h00;
      4'h9: seg_hex = 7'h10;
      4'hA: seg_hex = 7'h08;
      4'hB: seg_hex = 7'h03;
      4'hC: seg_hex = 7'h46;
      4'hD: seg_hex = 7'h21;
      4'hE: seg_hex = 7'h06;
      default: seg_hex = 7'h0E;
    endcase
  endfunction

  logic [3:0] cur_nib;
  logic [6:0] cur_pat;
  always_comb begin
    cur_nib = disp_reg[{idx_reg, 2'b00} +: 4];
    if (overflow_reg && disp_dec_reg) begin
      cur_pat = 7'h3F;
    end else if (disp_dec_reg && disp_blank_reg && lz_zero[idx_reg]) begin
      cur_pat = 7'h7F;
    end else begin
      cur_pat = seg_hex(cur_nib);
    end
  end

  // Anode and segment outputs are registered together, so they change on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_reg <= '0;
      idx_reg         <= '0;
      seg_n_reg       <= 7'h7F;
      digit_sel_n_reg <= 4'hF;
    end else if (enable) begin
      if (refresh_cnt_reg == REFRESH_LAST) begin
        refresh_cnt_reg <= '0;
        idx_reg         <= idx_reg + 2'd1;
      end else begin
        refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
      end
      digit_sel_n_reg <= ~(4'b0001 << idx_reg);
      seg_n_reg       <= cur_pat;
    end else begin
      refresh_cnt_reg <= '0;
      idx_reg         <= '0;
      digit_sel_n_reg <= 4'hF;
      seg_n_reg       <= 7'h7F;
    end
  end

  assign seg_n       = seg_n_reg;
  assign digit_sel_n = digit_sel_n_reg;
  assign busy        = (state_reg != IDLE);
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_ece453_seg7_display.sv
// Scoreboard bench for ece453_seg7_display, built with REFRESH_DIV = 4.
// Each load pushes its expected digit patterns and overflow flag into a queue.
// A monitor waits for a falling edge on busy, which marks a commit. It then
// pops one entry, checks the busy length and overflow, and scans one full
// display period to compare each digit.
module tb_ece453_seg7_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic        load;
  logic        mode_dec;
  logic        blank_lz;
  logic        enable;
  logic [6:0]  seg_n;
  logic [3:0]  digit_sel_n;
  logic        busy;
  logic        overflow;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  ece453_seg7_display #(.REFRESH_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .load        (load),
    .mode_dec    (mode_dec),
    .blank_lz    (blank_lz),
    .enable      (enable),
    .seg_n       (seg_n),
    .digit_sel_n (digit_sel_n),
    .busy        (busy),
    .overflow    (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [6:0] d3, input logic [6:0] d2,
                          input logic [6:0] d1, input logic [6:0] d0, input logic ovf);
    exp_t e;
    e.segs = {d3, d2, d1, d0};
    e.ovf  = ovf;
    sb_q.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] v, input logic m, input logic b);
    @(posedge clk); #1;
    value_in = v; mode_dec = m; blank_lz = b; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Monitor: a falling edge on busy with reset low is one committed result.
  initial begin : monitor
    int run;
    int fr;
    exp_t e;
    logic [3:0] seen;
    logic [6:0] got [4];
    run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
      end else if (busy) begin
        run++;
      end else if (run > 0) begin
        fr  = run;
        run = 0;
        if (sb_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_commit: got a commit, required none queued");
        end else begin
          e = sb_q.pop_front();
          check("busy_len", fr, 17);
          check("overflow", overflow, e.ovf);
          seen = '0;
          for (int i = 0; i < 4; i++) got[i] = 7'h00;
          for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (busy) run++;
            for (int i = 0; i < 4; i++) begin
              if (digit_sel_n == ~(4'b0001 << i) && !seen[i]) begin
                seen[i] = 1'b1;
                got[i]  = seg_n;
              end
            end
          end
          for (int i = 0; i < 4; i++) begin
            if (!seen[i]) begin
              tests_run++;
              tests_failed++;
              $display("FAIL digit%0d_seen: got never selected, required selected", i);
            end else begin
              check($sformatf("digit%0d", i), got[i], e.segs[7*i +: 7]);
            end
          end
          $display("[TB] commit: ovf=%0b digits3..0=%h %h %h %h busy_len=%0d",
                   overflow, got[3], got[2], got[1], got[0], fr);
        end
      end
    end
  end

  initial begin : stim
    logic [3:0] exp_sel;
    logic [3:0] seen;
    logic [6:0] got [4];
    int lo;
    reset = 1'b1; load = 1'b0; value_in = '0; mode_dec = 1'b0; blank_lz = 1'b0; enable = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_seg_n", seg_n, 7'h7F);
    check("rst_digit_sel_n", digit_sel_n, 4'hF);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    $display("[TB] reset state checked");

    // Idle scan: digit i is shown for four cycles, and every slot shows 0.
    @(posedge clk); #2;
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      exp_sel = 4'hF ^ (4'b0001 << (k / 4));
      check("scan_sel", digit_sel_n, exp_sel);
      check("scan_seg", seg_n, 7'h40);
    end
    check("scan_busy", busy, 1'b0);
    check("scan_overflow", overflow, 1'b0);
    $display("[TB] idle scan checked");

    // 1234 decimal: digit0 = 4, digit1 = 3, digit2 = 2, digit3 = 1.
    push_exp(7'h79, 7'h24, 7'h30, 7'h19, 1'b0);
    do_load(16'd1234, 1'b1, 1'b0);
    wait_idle();
    repeat (20) @(posedge clk);

    // 0xBEEF in hex mode shows b, E, E, F.
    push_exp(7'h03, 7'h06, 7'h06, 7'h0E, 1'b0);
    do_load(16'hBEEF, 1'b0, 1'b0);
    wait_idle();
    repeat (20) @(posedge clk);

    // 0xBEEF (48879) in decimal mode overflows and shows dashes.
    push_exp(7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);
    do_load(16'hBEEF, 1'b1, 1'b0);
    wait_idle();
    repeat (20) @(posedge clk);

    // Leading-zero blanking.
    push_exp(7'h7F, 7'h7F, 7'h7F, 7'h78, 1'b0);
    do_load(16'd7, 1'b1, 1'b1);
    wait_idle();
    repeat (20) @(posedge clk);
    push_exp(7'h7F, 7'h7F, 7'h7F, 7'h40, 1'b0);
    do_load(16'd0, 1'b1, 1'b1);
    wait_idle();
    repeat (20) @(posedge clk);

    // Loads while busy: 9 is replaced by 42, so only 5 and then 42 commit.
    push_exp(7'h40, 7'h40, 7'h40, 7'h12, 1'b0);
    push_exp(7'h40, 7'h40, 7'h19, 7'h24, 1'b0);
    do_load(16'd5, 1'b1, 1'b0);
    do_load(16'd9, 1'b1, 1'b0);
    @(posedge clk);
    do_load(16'd42, 1'b1, 1'b0);
    wait_idle();
    lo = 0;
    while (!busy && lo < 5) begin
      lo++;
      @(posedge clk); #1;
    end
    check("pending_gap", lo, 1);
    wait_idle();
    repeat (20) @(posedge clk);

    // Reset during a conversion: outputs return to reset values and nothing commits.
    do_load(16'd1234, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_seg_n", seg_n, 7'h7F);
    check("midrst_sel", digit_sel_n, 4'hF);
    check("midrst_ovf", overflow, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("midrst_idle", busy, 1'b0);
    seen = '0;
    for (int i = 0; i < 4; i++) got[i] = 7'h00;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (digit_sel_n == ~(4'b0001 << i) && !seen[i]) begin
          seen[i] = 1'b1;
          got[i]  = seg_n;
        end
      end
    end
    check("midrst_seen", seen, 4'hF);
    for (int i = 0; i < 4; i++) check($sformatf("midrst_digit%0d", i), got[i], 7'h40);
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] mid-conversion reset checked");

    // Disable: dark on the next cycle, held dark, then restart at digit0.
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    check("dis_sel", digit_sel_n, 4'hF);
    check("dis_seg", seg_n, 7'h7F);
    repeat (6) @(posedge clk);
    #1;
    check("dis_hold_sel", digit_sel_n, 4'hF);
    enable = 1'b1;
    @(posedge clk); #1;
    check("reen_sel", digit_sel_n, 4'hE);
    check("reen_seg", seg_n, 7'h40);
    $display("[TB] enable gating checked");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
